// File: rtl/z80_pkg.sv
// Shared Z80 I/O definitions: sequencer states, op/mode encodings,
// flag bit positions and the flag helpers used by the I/O sequencer.
package z80_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3,
    XFER,
    DONE
  } io_state_e;

  typedef enum logic [1:0] {
    MODE_SINGLE,
    MODE_INC,
    MODE_DEC,
    MODE_RSVD
  } io_mode_e;

  localparam logic OP_IN  = 1'b0;
  localparam logic OP_OUT = 1'b1;

  localparam int FLAG_S = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_Y = 5;
  localparam int FLAG_H = 4;
  localparam int FLAG_X = 3;
  localparam int FLAG_P = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  // IN r,(C): S/Z/P from the byte, H=N=0, undocumented Y/X and C kept.
  function automatic logic [7:0] in_flags(
    input logic [7:0] d,
    input logic [7:0] f
  );
    logic [7:0] r;
    r = '0;
    r[FLAG_S] = d[7];
    r[FLAG_Z] = (d == 8'h00);
    r[FLAG_Y] = f[FLAG_Y];
    r[FLAG_H] = 1'b0;
    r[FLAG_X] = f[FLAG_X];
    r[FLAG_P] = ~^d;
    r[FLAG_N] = 1'b0;
    r[FLAG_C] = f[FLAG_C];
    return r;
  endfunction

  function automatic logic [7:0] blk_flags(
    input logic [7:0] b,
    input logic [7:0] f
  );
    logic [7:0] r;
    r = f;
    r[FLAG_Z] = (b == 8'h00);
    r[FLAG_N] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/z80_io_wait_gen.sv
// TW cycle counter: mandatory wait plus EXTRA_WAIT automatic waits,
// then extends TW for as long as wait_n is sampled low.
module z80_io_wait_gen
  import z80_pkg::*;
#(
  parameter int EXTRA_WAIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic in_tw,
  input  logic wait_n,
  output logic tw_done
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 3'(EXTRA_WAIT);
    end else if (in_tw && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign tw_done = in_tw && (cnt == 3'd0) && wait_n;

endmodule

// File: rtl/z80_io_seq.sv
// Z80 I/O bus sequencer for IN/OUT and block INI/IND/OUTI/OUTD.
// Define Z80_IO_REPEAT_EN to enable the repeating (xIR/xDR) forms.
module z80_io_seq
  import z80_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int EXTRA_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [1:0]        mode,
  input  logic              repeat_i,
  input  logic [ADDR_W-1:0] bc_in,
  input  logic [15:0]       hl_in,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        f_in,
  output logic [ADDR_W-1:0] io_addr,
  output logic              iorq,
  output logic              rd,
  output logic              wr,
  input  logic              wait_n,
  input  logic [DATA_W-1:0] io_din,
  output logic [DATA_W-1:0] io_dout,
  output logic              xfer_valid,
  input  logic              xfer_ready,
  output logic [15:0]       xfer_addr,
  output logic [DATA_W-1:0] xfer_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] bc_out,
  output logic [15:0]       hl_out,
  output logic [7:0]        f_out
);

`ifdef Z80_IO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  io_state_e state, state_nx;
  io_mode_e  mode_r;

  logic              op_r;
  logic              rep_r;
  logic [ADDR_W-1:0] bc_r;
  logic [15:0]       hl_r;
  logic [DATA_W-1:0] wd_r;
  logic [7:0]        f_r;
  logic [7:0]        f_res;
  logic [ADDR_W-1:0] bc_hold;
  logic [15:0]       hl_hold;
  logic [7:0]        f_hold;

  logic        is_block;
  logic        rep_en;
  logic        tw_done;
  logic        iter_end;
  logic        more;
  logic        in_bus;
  logic        strobe;
  logic [7:0]  b_next;
  logic [15:0] hl_next;

  assign is_block = (mode_r == MODE_INC) || (mode_r == MODE_DEC);
  assign rep_en   = REP_EN && rep_r;
  assign b_next   = bc_r[ADDR_W-1 -: 8] - 8'd1;
  assign hl_next  = (mode_r == MODE_DEC) ? hl_r - 16'd1
                                         : hl_r + 16'd1;
  assign more     = rep_en && (b_next != 8'h00);

  // Block IN finishes an iteration on the handshake, block OUT at T3.
  assign iter_end =
    (state == T3 && is_block && op_r == OP_OUT) ||
    (state == XFER && xfer_ready);

  z80_io_wait_gen #(
    .EXTRA_WAIT(EXTRA_WAIT)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .load   (state == T2),
    .in_tw  (state == TW),
    .wait_n (wait_n),
    .tw_done(tw_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = T1;
      T1:   state_nx = T2;
      T2:   state_nx = TW;
      TW:   if (tw_done) state_nx = T3;
      T3: begin
        if (!is_block)          state_nx = DONE;
        else if (op_r == OP_IN) state_nx = XFER;
        else if (more)          state_nx = T1;
        else                    state_nx = DONE;
      end
      XFER: begin
        if (xfer_ready) state_nx = more ? T1 : DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r    <= OP_IN;
      mode_r  <= MODE_SINGLE;
      rep_r   <= 1'b0;
      bc_r    <= '0;
      hl_r    <= '0;
      wd_r    <= '0;
      f_r     <= '0;
      f_res   <= '0;
      rdata   <= '0;
      bc_hold <= '0;
      hl_hold <= '0;
      f_hold  <= '0;
    end else begin
      if (state == IDLE && start) begin
        op_r   <= op;
        mode_r <= io_mode_e'(mode);
        rep_r  <= repeat_i;
        bc_r   <= bc_in;
        hl_r   <= hl_in;
        wd_r   <= wdata;
        f_r    <= f_in;
        f_res  <= f_in;
      end
      if (state == T3 && op_r == OP_IN) begin
        rdata <= io_din;
        if (!is_block) f_res <= in_flags(io_din[7:0], f_r);
      end
      if (iter_end) begin
        bc_r[ADDR_W-1 -: 8] <= b_next;
        hl_r                <= hl_next;
        f_res               <= blk_flags(b_next, f_r);
      end
      if (state == DONE) begin
        bc_hold <= bc_r;
        hl_hold <= hl_r;
        f_hold  <= f_res;
      end
    end
  end

  assign in_bus = (state == T1) || (state == T2) ||
                  (state == TW) || (state == T3);
  assign strobe = (state == T2) || (state == TW) ||
                  (state == T3);

  assign io_addr    = in_bus ? bc_r : '0;
  assign io_dout    = (in_bus && op_r == OP_OUT) ? wd_r : '0;
  assign iorq       = strobe;
  assign rd         = strobe && (op_r == OP_IN);
  assign wr         = strobe && (op_r == OP_OUT);
  assign xfer_valid = (state == XFER);
  assign xfer_addr  = hl_r;
  assign xfer_data  = rdata;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  assign bc_out = done ? bc_r  : bc_hold;
  assign hl_out = done ? hl_r  : hl_hold;
  assign f_out  = done ? f_res : f_hold;

endmodule

// File: tb/tb_z80_io_seq.sv
// Directed bench for z80_io_seq; block expectations follow
// Z80_IO_REPEAT_EN as defined for the build.
module tb_z80_io_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [1:0]  mode;
  logic        repeat_i;
  logic [15:0] bc_in;
  logic [15:0] hl_in;
  logic [7:0]  wdata;
  logic [7:0]  f_in;
  logic [15:0] io_addr;
  logic        iorq;
  logic        rd;
  logic        wr;
  logic        wait_n;
  logic [7:0]  io_din;
  logic [7:0]  io_dout;
  logic        xfer_valid;
  logic        xfer_ready;
  logic [15:0] xfer_addr;
  logic [7:0]  xfer_data;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic [15:0] bc_out;
  logic [15:0] hl_out;
  logic [7:0]  f_out;

  int n_cmp = 0;
  int n_mis = 0;

  int          lat, n_rd, n_wr, n_io, n_x, wr_last;
  logic        got_done;
  logic [15:0] bus_addr, x_first, x_second, x_last;
  logic [7:0]  bus_dout, x_data;

  z80_io_seq #(
    .DATA_W(8),
    .ADDR_W(16),
    .EXTRA_WAIT(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .mode(mode), .repeat_i(repeat_i), .bc_in(bc_in),
    .hl_in(hl_in), .wdata(wdata), .f_in(f_in),
    .io_addr(io_addr), .iorq(iorq), .rd(rd), .wr(wr),
    .wait_n(wait_n), .io_din(io_din), .io_dout(io_dout),
    .xfer_valid(xfer_valid), .xfer_ready(xfer_ready),
    .xfer_addr(xfer_addr), .xfer_data(xfer_data),
    .busy(busy), .done(done), .rdata(rdata),
    .bc_out(bc_out), .hl_out(hl_out), .f_out(f_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic o, input logic [1:0] m,
                     input logic rep, input logic [15:0] bc,
                     input logic [15:0] hl, input logic [7:0] wd,
                     input logic [7:0] f, input int wn_rise,
                     input logic restart, input int limit);
    op = o; mode = m; repeat_i = rep;
    bc_in = bc; hl_in = hl; wdata = wd; f_in = f;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; n_rd = 0; n_wr = 0; n_io = 0; n_x = 0;
    wr_last = 0; got_done = 1'b0;
    bus_addr = '0; bus_dout = '0;
    x_first = '0; x_second = '0; x_last = '0; x_data = '0;
    while (lat < limit) begin
      wait_n = (lat >= wn_rise);
      if (rd) n_rd++;
      if (iorq) n_io++;
      if (wr) begin n_wr++; wr_last = lat; bus_dout = io_dout; end
      if (rd || wr) bus_addr = io_addr;
      if (xfer_valid && xfer_ready) begin
        if (n_x == 0) x_first = xfer_addr;
        if (n_x == 1) x_second = xfer_addr;
        x_last = xfer_addr;
        x_data = xfer_data;
        n_x++;
      end
      if (done) begin got_done = 1'b1; break; end
      if (restart && lat == 2) begin start = 1'b1; bc_in = 16'h0000; end
      else start = 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    wait_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; mode = 2'd0;
    repeat_i = 1'b0; bc_in = '0; hl_in = '0; wdata = '0;
    f_in = '0; wait_n = 1'b1; io_din = '0; xfer_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_ctl", {busy, done, iorq, rd, wr, xfer_valid}, 0);
    chk("rst_regs", {rdata, bc_out, hl_out, f_out}, 0);
    chk("rst_bus", {io_addr, io_dout}, 0);
    reset = 1'b0;
    tick();

    io_din = 8'h00;
    run(1'b0, 2'd0, 1'b0, 16'h12FE, 16'h1111, 8'h00, 8'h29,
        0, 1'b0, 20);
    chk("in_done", got_done, 1);
    chk("in_lat", lat, 5);
    chk("in_rd", n_rd, 3);
    chk("in_iorq", n_io, 3);
    chk("in_wr", n_wr, 0);
    chk("in_addr", bus_addr, 16'h12FE);
    chk("in_rdata", rdata, 8'h00);
    chk("in_f", f_out, 8'h6D);
    chk("in_bc_hl", {bc_out, hl_out}, 32'h12FE_1111);
    tick();
    chk("in_after", {done, busy}, 0);
    chk("in_hold_f", f_out, 8'h6D);

    run(1'b1, 2'd0, 1'b0, 16'hABCD, 16'h2222, 8'h5A, 8'h93,
        6, 1'b0, 30);
    chk("out_done", got_done, 1);
    chk("out_lat", lat, 8);
    chk("out_wr", n_wr, 6);
    chk("out_wr_last", wr_last, 7);
    chk("out_rd", n_rd, 0);
    chk("out_addr", bus_addr, 16'hABCD);
    chk("out_dout", bus_dout, 8'h5A);
    chk("out_f", f_out, 8'h93);
    chk("out_bc", bc_out, 16'hABCD);
    tick();

    io_din = 8'h81;
    run(1'b0, 2'd3, 1'b1, 16'h0456, 16'h3333, 8'h00, 8'h00,
        0, 1'b1, 20);
    chk("m3_lat", lat, 5);
    chk("m3_rdata", rdata, 8'h81);
    chk("m3_f", f_out, 8'h84);
    chk("m3_bc_hl", {bc_out, hl_out}, 32'h0456_3333);
    chk("m3_nx", n_x, 0);
    tick();

    io_din = 8'hA5;
    run(1'b0, 2'd1, 1'b1, 16'h0310, 16'h8000, 8'h00, 8'hFF,
        0, 1'b0, 60);
    chk("inir_done", got_done, 1);
    chk("inir_data", x_data, 8'hA5);
    chk("inir_first", x_first, 16'h8000);
`ifdef Z80_IO_REPEAT_EN
    chk("inir_lat", lat, 16);
    chk("inir_nx", n_x, 3);
    chk("inir_last", x_last, 16'h8002);
    chk("inir_bc_hl", {bc_out, hl_out}, 32'h0010_8003);
    chk("inir_f", f_out, 8'hFF);
`else
    chk("inir_lat", lat, 6);
    chk("inir_nx", n_x, 1);
    chk("inir_last", x_last, 16'h8000);
    chk("inir_bc_hl", {bc_out, hl_out}, 32'h0210_8001);
    chk("inir_f", f_out, 8'hBF);
`endif
    tick();

    io_din = 8'h3C;
    run(1'b0, 2'd2, 1'b1, 16'h0077, 16'h0000, 8'h00, 8'h00,
        0, 1'b0, 2000);
    chk("indr_done", got_done, 1);
    chk("indr_first", x_first, 16'h0000);
    chk("indr_data", x_data, 8'h3C);
`ifdef Z80_IO_REPEAT_EN
    chk("indr_lat", lat, 1281);
    chk("indr_nx", n_x, 256);
    chk("indr_second", x_second, 16'hFFFF);
    chk("indr_last", x_last, 16'hFF01);
    chk("indr_bc_hl", {bc_out, hl_out}, 32'h0077_FF00);
    chk("indr_f", f_out, 8'h42);
`else
    chk("indr_lat", lat, 6);
    chk("indr_nx", n_x, 1);
    chk("indr_bc_hl", {bc_out, hl_out}, 32'hFF77_FFFF);
    chk("indr_f", f_out, 8'h02);
`endif
    tick();

    run(1'b1, 2'd1, 1'b1, 16'h0240, 16'h1000, 8'h77, 8'h00,
        0, 1'b0, 40);
    chk("otir_done", got_done, 1);
    chk("otir_nx", n_x, 0);
    chk("otir_dout", bus_dout, 8'h77);
`ifdef Z80_IO_REPEAT_EN
    chk("otir_lat", lat, 9);
    chk("otir_wr", n_wr, 6);
    chk("otir_bc_hl", {bc_out, hl_out}, 32'h0040_1002);
    chk("otir_f", f_out, 8'h42);
`else
    chk("otir_lat", lat, 5);
    chk("otir_wr", n_wr, 3);
    chk("otir_bc_hl", {bc_out, hl_out}, 32'h0140_1001);
    chk("otir_f", f_out, 8'h02);
`endif
    tick();

    xfer_ready = 1'b0;
    op = 1'b0; mode = 2'd1; repeat_i = 1'b1;
    bc_in = 16'h0500; hl_in = 16'h4000; f_in = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !xfer_valid; i++) tick();
    chk("xr_valid", xfer_valid, 1);
    tick();
    chk("xr_stall", {xfer_valid, busy, xfer_addr}, {2'b11, 16'h4000});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("xr_rst", {xfer_valid, busy, done, iorq}, 0);
    chk("xr_outs", {bc_out, hl_out, f_out}, 0);
    n_x = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) n_x++;
      tick();
    end
    chk("xr_nodone", n_x, 0);
    xfer_ready = 1'b1;

    wait_n = 1'b0;
    op = 1'b0; mode = 2'd0; bc_in = 16'h0099;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("tw_hold", {rd, iorq, io_addr}, {2'b11, 16'h0099});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("tw_rst", {iorq, rd, wr, busy, io_addr}, 0);
    wait_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/z80_io_seq.md
Z80_IO_SEQ -- requirements
Module: z80_io_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, I/O data width.
REQ-002 SHALL have parameter ADDR_W, default 16, I/O address width; {B,C} maps onto it.
REQ-003 SHALL have parameter EXTRA_WAIT, default 0, automatic wait states added after the mandatory one (0..7).
REQ-004 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high.
REQ-005 SHALL have ports: start in 1, command strobe; op in 1 (0=IN, 1=OUT); mode in 2 (0=single, 1=block-inc, 2=block-dec, 3=reserved).
REQ-006 SHALL have ports: repeat_i in 1; bc_in in ADDR_W; hl_in in 16; wdata in DATA_W; f_in in 8.
REQ-007 SHALL have ports: io_addr out ADDR_W; iorq out 1; rd out 1; wr out 1; wait_n in 1; io_din in DATA_W; io_dout out DATA_W.
REQ-008 SHALL have ports: xfer_valid out 1; xfer_ready in 1; xfer_addr out 16; xfer_data out DATA_W (block IN bytes to memory side).
REQ-009 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); rdata out DATA_W; bc_out out ADDR_W; hl_out out 16; f_out out 8.

Function
REQ-010 SHALL use states IDLE, T1, T2, TW, T3, XFER, DONE.
REQ-011 SHALL, in IDLE with start=1, latch op, mode, repeat_i, bc_in, hl_in, wdata, f_in, raise busy, and enter T1; start SHALL be ignored while busy.
REQ-012 SHALL drive io_addr = latched BC from T1 through T3.
REQ-013 SHALL assert iorq plus rd (IN) or wr (OUT) in T2, TW and T3.
REQ-014 SHALL spend 1+EXTRA_WAIT cycles in TW, then remain in TW while wait_n=0 is sampled.
REQ-015 SHALL latch io_din into rdata on the T3 edge for IN; io_dout = wdata from T1 through T3 for OUT.
REQ-016 SHALL, for single IN, set f_out = {rdata[7], rdata==0, f_in[5], 0, f_in[3], even parity(rdata), 0, f_in[0]}; single OUT SHALL leave f_out = f_in.
REQ-017 SHALL, for block IN, go T3 -> XFER and hold xfer_valid=1 with xfer_addr=HL and xfer_data=rdata until xfer_ready=1; for block OUT, skip XFER.
REQ-018 SHALL, per block iteration, decrement B modulo 256 (00 -> FF) and adjust HL +1 (mode 1) or -1 (mode 2) with 16-bit wrap.
REQ-019 SHALL, for block ops, set f_out Z = (new B==0), N=1, and keep all other bits from f_in.
REQ-020 SHALL, with repeat set and new B != 0, return to T1 for another iteration; otherwise enter DONE.
REQ-021 SHALL pulse done for the single DONE cycle, present final rdata, bc_out, hl_out and f_out, and return to IDLE.
REQ-022 SHALL treat mode 3 as single.
REQ-023 SHALL hold bc_out, hl_out and f_out stable outside DONE; their values are undefined until the first DONE.

Reset
REQ-024 SHALL, on reset, enter IDLE and clear busy, done, iorq, rd, wr, xfer_valid, rdata, io_dout, io_addr, bc_out, hl_out and f_out.
REQ-025 SHALL let reset abort any state, including TW with wait_n=0 and XFER, and drop every strobe on the next edge.

Configuration
REQ-026 SHALL, with Z80_IO_REPEAT_EN defined, honour repeat_i as in REQ-020.
REQ-027 SHALL, without Z80_IO_REPEAT_EN, ignore repeat_i so that every block command performs exactly one iteration.

Structure
REQ-028 SHALL take the state enum, op/mode encodings and flag bit indices from the shared z80 package.
REQ-029 SHALL place the TW cycle counter and wait_n sampling in sub-module z80_io_wait_gen.

Verification
REQ-030 SHALL cover: single IN, EXTRA_WAIT=0, BC=0x12FE, io_din=0x00, f_in=0x29 -> io_addr 0x12FE, rd for 3 cycles, done 5 cycles after start, rdata 0x00, f_out 0x6D.
REQ-031 SHALL cover: single OUT with wait_n low for 3 TW samples -> T3 is entered on the first cycle wait_n=1, wr spans T2..T3, f_out=f_in.
REQ-032 SHALL cover: INIR with B=0x03, HL=0x8000 and REPEAT_EN defined -> 3 xfers to 0x8000..0x8002, final B 0x00, HL 0x8003, Z=1, N=1.
REQ-033 SHALL cover: INDR with B=0x00 -> 256 iterations, HL wraps 0x0000 -> 0xFFFF, final B 0x00.
REQ-034 SHALL cover: the same INIR without REPEAT_EN -> 1 xfer, B 0x02, Z=0.
REQ-035 SHALL cover: reset while in XFER with xfer_ready=0 -> next cycle IDLE, xfer_valid=0, busy=0, no done pulse.
